fibre_a_buffer: RTL and testbench

FIBRE_A_BUFFER -- requirements
Module: fibre_a_buffer

---
 rtl/fibre_a_buffer_pkg.sv | 14 +
 rtl/fibre_a_buffer_bank.sv | 37 +++
 rtl/fibre_a_buffer.sv | 140 ++++++++++++++
 tb/tb_fibre_a_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fibre_a_buffer_pkg.sv
// Shared LoAS definitions for the fibre_a ping-pong buffer.
// Holds the bank lifecycle encoding and the default geometry.
package fibre_a_buffer_pkg;

   localparam int unsigned DEF_TIMESTEPS  = 4;
   localparam int unsigned DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      BANK_FREE    = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_READY   = 2'd2
   } bank_state_e;

endpackage

// File: rtl/fibre_a_buffer_bank.sv
// One fibre_a storage bank: single write port, registered read port.
// Contents are not reset; validity is tracked by the owning buffer.
module fibre_bank
   import fibre_a_buffer_pkg::*;
#(
   parameter int unsigned TIMESTEPS  = DEF_TIMESTEPS,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [TIMESTEPS-1:0]  wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [TIMESTEPS-1:0]  rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [TIMESTEPS-1:0] mem_q [DEPTH];
   logic [TIMESTEPS-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fibre_a_buffer.sv
// Ping-pong fibre_a buffer between the loader and the TPPE.
// One bank fills while the other is read; release frees a bank.
module fibre_a_buffer
   import fibre_a_buffer_pkg::*;
#(
   parameter int unsigned TIMESTEPS  = DEF_TIMESTEPS,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [TIMESTEPS-1:0]  wr_data,
   input  logic                  wr_last,
   output logic                  load_ready,
   input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
   input  logic                  fibre_a_read_en,
   output logic [TIMESTEPS-1:0]  fibre_a_data,
   output logic                  fibre_a_valid,
   output logic                  rd_bank_valid,
   output logic [ADDR_WIDTH:0]   rd_len,
   input  logic                  rd_release,
   output logic                  rd_err
);

   localparam int unsigned LW = ADDR_WIDTH + 1;

   bank_state_e          state_q [2];
   bank_state_e          state_d [2];
   logic [LW-1:0]        len_q [2];
   logic [LW-1:0]        len_d [2];
   logic                 wr_bank_q, wr_bank_d;
   logic                 rd_bank_q, rd_bank_d;

   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_ok_q, resp_ok_d;
   logic                 resp_bank_q, resp_bank_d;
   logic                 rd_err_q, rd_err_d;

   logic                 wr_accept;
   logic                 rel_accept;
   logic                 rd_in_range;
   logic                 rd_hit;
   logic [LW-1:0]        wr_len;
   logic [1:0]           bank_we;
   logic [1:0]           bank_re;
   logic [TIMESTEPS-1:0] bank_rdata [2];

   assign load_ready    = (state_q[wr_bank_q] != BANK_READY);
   assign rd_bank_valid = (state_q[rd_bank_q] == BANK_READY);
   assign rd_len        = rd_bank_valid ? len_q[rd_bank_q] : '0;

   assign wr_accept   = wr_en & load_ready;
   assign rel_accept  = rd_release & rd_bank_valid;
   assign rd_in_range = ({1'b0, fibre_a_addr} < rd_len);
   assign rd_hit      = fibre_a_read_en & rd_bank_valid & rd_in_range;
   assign wr_len      = LW'(wr_addr) + LW'(1);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign bank_we[b] = wr_accept & (wr_bank_q == 1'(b));
      assign bank_re[b] = rd_hit & (rd_bank_q == 1'(b));

      fibre_bank #(
         .TIMESTEPS  (TIMESTEPS),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
         .clk     (clk),
         .we_i    (bank_we[b]),
         .waddr_i (wr_addr),
         .wdata_i (wr_data),
         .re_i    (bank_re[b]),
         .raddr_i (fibre_a_addr),
         .rdata_o (bank_rdata[b])
      );
   end

   // Write and release always target different banks: the write bank
   // is never READY and the read bank is only released while READY.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;

      if (wr_accept) begin
         if (wr_last) begin
            state_d[wr_bank_q] = BANK_READY;
            len_d[wr_bank_q]   = wr_len;
            wr_bank_d          = ~wr_bank_q;
         end else if (state_q[wr_bank_q] == BANK_FREE) begin
            state_d[wr_bank_q] = BANK_FILLING;
         end
      end

      if (rel_accept) begin
         state_d[rd_bank_q] = BANK_FREE;
         len_d[rd_bank_q]   = '0;
         rd_bank_d          = ~rd_bank_q;
      end
   end

   always_comb begin
      resp_valid_d = fibre_a_read_en & rd_bank_valid;
      resp_ok_d    = rd_hit;
      resp_bank_d  = rd_bank_q;
      rd_err_d     = fibre_a_read_en & ~rd_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= BANK_FREE;
            len_q[b]   <= '0;
         end
         wr_bank_q    <= 1'b0;
         rd_bank_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_ok_q    <= 1'b0;
         resp_bank_q  <= 1'b0;
         rd_err_q     <= 1'b0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            state_q[b] <= state_d[b];
            len_q[b]   <= len_d[b];
         end
         wr_bank_q    <= wr_bank_d;
         rd_bank_q    <= rd_bank_d;
         resp_valid_q <= resp_valid_d;
         resp_ok_q    <= resp_ok_d;
         resp_bank_q  <= resp_bank_d;
         rd_err_q     <= rd_err_d;
      end
   end

   // Data is gated so out-of-range and idle cycles present zero.
   assign fibre_a_data  = resp_ok_q ? bank_rdata[resp_bank_q] : '0;
   assign fibre_a_valid = resp_valid_q;
   assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_fibre_a_buffer.sv
// Directed bench for fibre_a_buffer with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fibre_a_buffer;

   localparam int TS = 4;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [TS-1:0] wr_data;
   logic          wr_last;
   logic          load_ready;
   logic [AW-1:0] fibre_a_addr;
   logic          fibre_a_read_en;
   logic [TS-1:0] fibre_a_data;
   logic          fibre_a_valid;
   logic          rd_bank_valid;
   logic [AW:0]   rd_len;
   logic          rd_release;
   logic          rd_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fibre_a_buffer #(
      .TIMESTEPS  (TS),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .wr_last         (wr_last),
      .load_ready      (load_ready),
      .fibre_a_addr    (fibre_a_addr),
      .fibre_a_read_en (fibre_a_read_en),
      .fibre_a_data    (fibre_a_data),
      .fibre_a_valid   (fibre_a_valid),
      .rd_bank_valid   (rd_bank_valid),
      .rd_len          (rd_len),
      .rd_release      (rd_release),
      .rd_err          (rd_err)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en           = 1'b0;
      wr_last         = 1'b0;
      fibre_a_read_en = 1'b0;
      rd_release      = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [TS-1:0] d,
                     input logic last);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_last = last;
      step();
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      fibre_a_read_en = 1'b1;
      fibre_a_addr    = a;
      step();
      idle();
   endtask

   task automatic chk_resp(input string tag, input logic v,
                           input logic [TS-1:0] d, input logic e);
      check({tag, "_valid"}, 32'(fibre_a_valid), 32'(v));
      check({tag, "_data"}, 32'(fibre_a_data), 32'(d));
      check({tag, "_err"}, 32'(rd_err), 32'(e));
   endtask

   initial begin
      rst          = 1'b1;
      wr_addr      = '0;
      wr_data      = '0;
      fibre_a_addr = '0;
      idle();
      step();
      step();
      check("rst_load_ready", 32'(load_ready), 32'd1);
      check("rst_rd_valid", 32'(rd_bank_valid), 32'd0);
      check("rst_rd_len", 32'(rd_len), 32'd0);
      chk_resp("rst", 1'b0, 4'h0, 1'b0);
      rst = 1'b0;
      step();

      // Fill bank0 with five entries
      wr(8'd0, 4'h1, 1'b0);
      wr(8'd1, 4'h2, 1'b0);
      wr(8'd2, 4'h4, 1'b0);
      wr(8'd3, 4'h8, 1'b0);
      check("fill_load_ready", 32'(load_ready), 32'd1);
      check("fill_rd_valid", 32'(rd_bank_valid), 32'd0);
      wr(8'd4, 4'hF, 1'b1);
      check("b0_rd_valid", 32'(rd_bank_valid), 32'd1);
      check("b0_rd_len", 32'(rd_len), 32'd5);
      check("b0_load_ready", 32'(load_ready), 32'd1);

      rd(8'd3);
      chk_resp("rd3", 1'b1, 4'h8, 1'b0);
      step();
      chk_resp("rd_idle", 1'b0, 4'h0, 1'b0);

      // Back-to-back reads
      fibre_a_read_en = 1'b1;
      fibre_a_addr    = 8'd0;
      step();
      chk_resp("b2b0", 1'b1, 4'h1, 1'b0);
      fibre_a_addr = 8'd4;
      step();
      chk_resp("b2b4", 1'b1, 4'hF, 1'b0);
      idle();

      rd(8'd5);
      chk_resp("oob5", 1'b1, 4'h0, 1'b1);

      rd_release = 1'b1;
      step();
      idle();
      check("rel_rd_valid", 32'(rd_bank_valid), 32'd0);
      check("rel_rd_len", 32'(rd_len), 32'd0);
      rd(8'd0);
      chk_resp("rd_empty", 1'b0, 4'h0, 1'b1);

      // Release with nothing ready is ignored
      rd_release = 1'b1;
      step();
      idle();
      check("ign_rel_valid", 32'(rd_bank_valid), 32'd0);

      // Both banks READY: bank1 len 3, bank0 len 2
      wr(8'd0, 4'hA, 1'b0);
      wr(8'd1, 4'hB, 1'b0);
      wr(8'd2, 4'hC, 1'b1);
      check("b1_rd_len", 32'(rd_len), 32'd3);
      wr(8'd0, 4'hD, 1'b0);
      wr(8'd1, 4'hE, 1'b1);
      check("full_load_ready", 32'(load_ready), 32'd0);
      check("full_rd_len", 32'(rd_len), 32'd3);
      wr(8'd0, 4'h5, 1'b1);
      check("ign_wr_ready", 32'(load_ready), 32'd0);
      check("ign_wr_len", 32'(rd_len), 32'd3);
      rd(8'd2);
      chk_resp("b1_rd2", 1'b1, 4'hC, 1'b0);

      rd_release = 1'b1;
      step();
      idle();
      check("rel2_rd_len", 32'(rd_len), 32'd2);
      check("rel2_load_ready", 32'(load_ready), 32'd1);
      check("rel2_rd_valid", 32'(rd_bank_valid), 32'd1);

      // Read + release + wr_last on the other bank together
      wr(8'd0, 4'h6, 1'b0);
      fibre_a_read_en = 1'b1;
      fibre_a_addr    = 8'd0;
      rd_release      = 1'b1;
      wr_en           = 1'b1;
      wr_addr         = 8'd1;
      wr_data         = 4'h7;
      wr_last         = 1'b1;
      step();
      idle();
      chk_resp("same_cyc", 1'b1, 4'hD, 1'b0);
      check("same_rd_len", 32'(rd_len), 32'd2);
      check("same_rd_valid", 32'(rd_bank_valid), 32'd1);
      check("same_load_ready", 32'(load_ready), 32'd1);
      rd(8'd1);
      chk_resp("b1_new1", 1'b1, 4'h7, 1'b0);
      rd(8'd0);
      chk_resp("b1_new0", 1'b1, 4'h6, 1'b0);

      // Reset one cycle after a read issued mid-fill
      fibre_a_read_en = 1'b1;
      fibre_a_addr    = 8'd1;
      wr_en           = 1'b1;
      wr_addr         = 8'd0;
      wr_data         = 4'h3;
      step();
      idle();
      rst = 1'b1;
      step();
      check("rst2_valid", 32'(fibre_a_valid), 32'd0);
      check("rst2_data", 32'(fibre_a_data), 32'd0);
      check("rst2_rd_valid", 32'(rd_bank_valid), 32'd0);
      check("rst2_load_ready", 32'(load_ready), 32'd1);
      check("rst2_rd_len", 32'(rd_len), 32'd0);
      rst = 1'b0;

      wr(8'd0, 4'h9, 1'b1);
      check("post_rd_len", 32'(rd_len), 32'd1);
      rd(8'd0);
      chk_resp("post_rd0", 1'b1, 4'h9, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
